// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, runs a req/ack fetch from instruction memory and hands
// the fetched word to the control unit, raising a sticky fault on misalignment or timeout.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_CLK,
    input  logic [2:0]  PC_MUX_SELECT,
    input  logic [31:0] TARGET_ADR,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_REQ,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] MEM_INST,
    output logic        INST_ENB,
    output logic [31:0] PC,
    output logic        FETCH_FAULT
);

    typedef enum logic [1:0] {StIdle, StFetch, StValid, StFault} state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] inst_q, inst_d;
    logic        enb_q, enb_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] next_pc;

    always_comb begin
        unique case (PC_MUX_SELECT)
            3'd1:    next_pc = TARGET_ADR;
            3'd2:    next_pc = pc_q;
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        inst_d  = inst_q;
        enb_d   = enb_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                req_d   = 1'b1;
                addr_d  = pc_q;
                cnt_d   = '0;
            end
            StFetch: begin
                // An ACK on the same edge the limit is reached still wins.
                if (IMEM_ACK) begin
                    inst_d  = IMEM_RDATA;
                    enb_d   = 1'b1;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StValid;
                end else if (cnt_q == CntLast) begin
                    req_d   = 1'b0;
                    enb_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StValid: begin
                if (PC_CLK) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        addr_d  = next_pc;
                        enb_d   = 1'b0;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StFetch;
                    end else begin
                        enb_d   = 1'b0;
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                enb_d   = 1'b0;
                req_d   = 1'b0;
                fault_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            inst_q  <= '0;
            enb_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            inst_q  <= inst_d;
            enb_q   <= enb_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IMEM_ADDR   = addr_q;
    assign IMEM_REQ    = req_q;
    assign MEM_INST    = inst_q;
    assign INST_ENB    = enb_q;
    assign PC          = pc_q;
    assign FETCH_FAULT = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios then randomized fetch/advance traffic
// checked against a transaction-level PC/instruction model.
module tb_ifetch_unit;

    localparam logic [31:0] RstPc = 32'h0000_0000;
    localparam int          Tmo   = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PC_CLK = 1'b0;
    logic [2:0]  PC_MUX_SELECT = 3'd0;
    logic [31:0] TARGET_ADR = '0;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic [31:0] MEM_INST;
    logic        INST_ENB;
    logic [31:0] PC;
    logic        FETCH_FAULT;

    ifetch_unit #(.RESET_PC(RstPc), .TIMEOUT_CYC(Tmo)) dut (
        .CLK(CLK), .RST(RST), .PC_CLK(PC_CLK), .PC_MUX_SELECT(PC_MUX_SELECT),
        .TARGET_ADR(TARGET_ADR), .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ),
        .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .MEM_INST(MEM_INST),
        .INST_ENB(INST_ENB), .PC(PC), .FETCH_FAULT(FETCH_FAULT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: PC of the outstanding/held instruction, the held word, and the fault flag.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_fault;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_fault_state();
        check_eq("flt_fault", 32'(FETCH_FAULT), 32'd1);
        check_eq("flt_req", 32'(IMEM_REQ), 32'd0);
        check_eq("flt_enb", 32'(INST_ENB), 32'd0);
        check_eq("flt_pc", PC, m_pc);
        check_eq("flt_inst", MEM_INST, m_inst);
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        PC_CLK = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            IMEM_ACK = 1'($urandom_range(0, 1));
            IMEM_RDATA = $urandom;
            step();
            check_eq("rst_req", 32'(IMEM_REQ), 32'd0);
            check_eq("rst_enb", 32'(INST_ENB), 32'd0);
            check_eq("rst_inst", MEM_INST, 32'd0);
            check_eq("rst_fault", 32'(FETCH_FAULT), 32'd0);
            check_eq("rst_pc", PC, RstPc);
            check_eq("rst_addr", IMEM_ADDR, RstPc);
        end
        IMEM_ACK = 1'b0;
        RST = 1'b0;
        m_pc = RstPc;
        m_inst = '0;
        m_fault = 1'b0;
        step();
        check_eq("first_req", 32'(IMEM_REQ), 32'd1);
        check_eq("first_addr", IMEM_ADDR, RstPc);
    endtask

    // Called in the first cycle REQ is visible; ACK arrives in cycle 'lat' of the request.
    task automatic do_fetch(input int lat, input logic [31:0] data);
        for (int c = 1; c <= Tmo; c++) begin
            check_eq("f_req", 32'(IMEM_REQ), 32'd1);
            check_eq("f_addr", IMEM_ADDR, m_pc);
            check_eq("f_enb", 32'(INST_ENB), 32'd0);
            PC_CLK = 1'($urandom_range(0, 1));
            PC_MUX_SELECT = 3'($urandom_range(0, 7));
            TARGET_ADR = $urandom | 32'd1;
            IMEM_RDATA = $urandom;
            if (c == lat) begin
                IMEM_ACK = 1'b1;
                IMEM_RDATA = data;
            end
            step();
            IMEM_ACK = 1'b0;
            PC_CLK = 1'b0;
            if (c == lat) begin
                m_inst = data;
                check_eq("v_inst", MEM_INST, data);
                check_eq("v_enb", 32'(INST_ENB), 32'd1);
                check_eq("v_pc", PC, m_pc);
                check_eq("v_req", 32'(IMEM_REQ), 32'd0);
                check_eq("v_fault", 32'(FETCH_FAULT), 32'd0);
                return;
            end
        end
        m_fault = 1'b1;
        check_fault_state();
    endtask

    // Called in VALID; idles 'hold' cycles, then strobes PC_CLK.
    task automatic do_advance(input int hold, input logic [2:0] sel, input logic [31:0] tgt);
        logic [31:0] nxt;
        for (int i = 0; i < hold; i++) begin
            IMEM_ACK = 1'($urandom_range(0, 1));
            IMEM_RDATA = $urandom;
            step();
            IMEM_ACK = 1'b0;
            check_eq("hold_enb", 32'(INST_ENB), 32'd1);
            check_eq("hold_inst", MEM_INST, m_inst);
            check_eq("hold_req", 32'(IMEM_REQ), 32'd0);
        end
        PC_CLK = 1'b1;
        PC_MUX_SELECT = sel;
        TARGET_ADR = tgt;
        step();
        PC_CLK = 1'b0;
        if (sel == 3'd1) nxt = tgt;
        else if (sel == 3'd2) nxt = m_pc;
        else nxt = m_pc + 32'd4;
        if (nxt % 4 != 0) begin
            m_fault = 1'b1;
            check_fault_state();
        end else begin
            m_pc = nxt;
            check_eq("adv_req", 32'(IMEM_REQ), 32'd1);
            check_eq("adv_addr", IMEM_ADDR, nxt);
            check_eq("adv_pc", PC, nxt);
            check_eq("adv_enb", 32'(INST_ENB), 32'd0);
        end
    endtask

    task automatic hold_fault();
        for (int i = 0; i < 3; i++) begin
            PC_CLK = 1'($urandom_range(0, 1));
            IMEM_ACK = 1'($urandom_range(0, 1));
            step();
            check_fault_state();
        end
        PC_CLK = 1'b0;
        IMEM_ACK = 1'b0;
    endtask

    initial begin
        // Reset and first fetch
        do_reset(2);
        do_fetch(3, 32'h0000_0013);
        // Sequential with wrap
        do_advance(0, 3'd1, 32'hFFFF_FFF8);
        do_fetch(1, 32'hAAAA_0001);
        do_advance(1, 3'd0, 32'h0);
        do_fetch(2, 32'hAAAA_0002);
        do_advance(0, 3'd5, 32'h0);
        do_fetch(1, 32'hAAAA_0003);
        check_eq("wrap_pc", PC, 32'h0000_0000);
        // Branch and refetch
        do_advance(2, 3'd1, 32'h0000_0100);
        do_fetch(2, 32'hBBBB_0001);
        do_advance(0, 3'd2, 32'hFFFF_0000);
        do_fetch(3, 32'hBBBB_0002);
        check_eq("refetch_pc", PC, 32'h0000_0100);
        // Misaligned target
        do_advance(0, 3'd1, 32'h0000_0102);
        hold_fault();
        do_reset(1);
        // Timeout then ACK on the last allowed cycle
        do_fetch(Tmo + 1, 32'hCCCC_0001);
        hold_fault();
        do_reset(1);
        do_fetch(Tmo, 32'hCCCC_0002);
        // Reset mid-fetch with a late ACK
        do_advance(0, 3'd0, 32'h0);
        RST = 1'b1;
        step();
        check_eq("mid_req", 32'(IMEM_REQ), 32'd0);
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'hDEAD_BEEF;
        step();
        IMEM_ACK = 1'b0;
        check_eq("mid_inst", MEM_INST, 32'd0);
        check_eq("mid_enb", 32'(INST_ENB), 32'd0);
        check_eq("mid_req2", 32'(IMEM_REQ), 32'd0);
        do_reset(1);

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            logic [2:0]  sel;
            logic [31:0] tgt;
            int          lat;
            lat = ($urandom_range(0, 9) == 0) ? Tmo + 1 : int'($urandom_range(1, Tmo));
            do_fetch(lat, $urandom);
            if (m_fault) begin
                hold_fault();
                do_reset(int'($urandom_range(1, 2)));
                continue;
            end
            sel = 3'($urandom_range(0, 7));
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            do_advance(int'($urandom_range(0, 2)), sel, tgt);
            if (m_fault) begin
                hold_fault();
                do_reset(int'($urandom_range(1, 2)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", n_errors + 1);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
